// File: rtl/one_bit_alu.sv
// one_bit_alu: single-bit ALU slice with a registered output stage.
// Performs AND, OR, full-add or full-subtract on two 1-bit operands and a
// carry/borrow-in. Slices chain carryOut into the next slice's carryIn.
// Optional feature: define ONE_BIT_ALU_ZERO_FLAG_EN to add a registered
// zero flag output (zero = result==0).
module one_bit_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  input  logic       carryIn,
  input  logic [1:0] op,
  output logic       carryOut,
  output logic       result
`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
  ,
  output logic       zero
`endif
);

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  op_e  opSel;
  logic bEff;
  logic result_d;
  logic carry_d;
  logic result_q;
  logic carry_q;

  assign opSel = op_e'(op);

  // Next-state datapath; subtraction reuses the adder with an inverted B
  // operand, so carryOut=1 means no borrow and the first slice feeds carryIn=1.
  always_comb begin
    bEff     = in2;
    result_d = 1'b0;
    carry_d  = 1'b0;
    case (opSel)
      OP_AND: begin
        result_d = in1 & in2;
        carry_d  = 1'b0;
      end
      OP_OR: begin
        result_d = in1 | in2;
        carry_d  = 1'b0;
      end
      OP_ADD: begin
        bEff     = in2;
        result_d = in1 ^ bEff ^ carryIn;
        carry_d  = (in1 & bEff) | (in1 & carryIn) | (bEff & carryIn);
      end
      OP_SUB: begin
        bEff     = ~in2;
        result_d = in1 ^ bEff ^ carryIn;
        carry_d  = (in1 & bEff) | (in1 & carryIn) | (bEff & carryIn);
      end
      default: begin
        result_d = 1'b0;
        carry_d  = 1'b0;
      end
    endcase
  end

  // Output registers: capture every rising edge, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result   = result_q;
  assign carryOut = carry_q;

`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered alongside result; reset value is 0, not 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= ~result_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_one_bit_alu.sv
// tb_one_bit_alu: self-checking bench for one_bit_alu with directed sweeps,
// asynchronous reset checks, mid-cycle input changes and random stimulus.
module tb_one_bit_alu;

  logic       clk;
  logic       rst_n;
  logic       in1;
  logic       in2;
  logic       carryIn;
  logic [1:0] op;
  logic       carryOut;
  logic       result;
`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
  logic       zero;
`endif

  int total;
  int bad;

  one_bit_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .carryIn  (carryIn),
    .op       (op),
    .carryOut (carryOut),
    .result   (result)
`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arithmetic view of the slice.
  // ADD: a+b+cin, low bit is result, high bit is carry.
  // SUB: a-b-(1-cin); low bit is result, carryOut=1 when no borrow (value>=0).
  function automatic logic [1:0] modelAlu(input int o, input int a, input int b, input int c);
    int v;
    logic [1:0] r;
    r = 2'b00;
    case (o)
      0: r = {1'b0, 1'(a * b)};
      1: r = {1'b0, 1'((a + b) > 0 ? 1 : 0)};
      2: begin
        v = a + b + c;
        r = {1'(v / 2), 1'(v % 2)};
      end
      default: begin
        v = a - b - (1 - c);
        r = {1'(v >= 0 ? 1 : 0), 1'((v + 2) % 2)};
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input int o, input int a, input int b, input int c);
    @(negedge clk);
    op      = 2'(o);
    in1     = 1'(a);
    in2     = 1'(b);
    carryIn = 1'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input int o, input int a, input int b, input int c);
    logic [1:0] exp;
    exp = modelAlu(o, a, b, c);
    checkOutput({tag, ".result"}, result, exp[0]);
    checkOutput({tag, ".carry"}, carryOut, exp[1]);
`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
    checkOutput({tag, ".zero"}, zero, ~exp[0]);
`endif
  endtask

  initial begin
    int o, a, b, c;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b1;
    op      = 2'd0;
    in1     = 1'b0;
    in2     = 1'b0;
    carryIn = 1'b0;

    // Initial asynchronous reset
    #1 rst_n = 1'b0;
    #1;
    checkOutput("resetInit.result", result, 1'b0);
    checkOutput("resetInit.carry", carryOut, 1'b0);
`ifdef ONE_BIT_ALU_ZERO_FLAG_EN
    checkOutput("resetInit.zero", zero, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Load result=1, carryOut=1, then reset between edges
    applyStimulus(2, 1, 1, 1);
    checkAll("preReset", 2, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset.result", result, 1'b0);
    checkOutput("asyncReset.carry", carryOut, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("resetHold.result", result, 1'b0);
    checkOutput("resetHold.carry", carryOut, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("resetRelease.result", result, 1'b0);
    @(posedge clk);
    #1;
    checkAll("afterRelease", 2, 1, 1, 1);

    // Exhaustive sweep of all ops and input combinations
    for (int i = 0; i < 32; i++) begin
      o = i / 8;
      a = (i / 4) % 2;
      b = (i / 2) % 2;
      c = i % 2;
      applyStimulus(o, a, b, c);
      checkAll($sformatf("sweep%0d_%0d%0d%0d", o, a, b, c), o, a, b, c);
    end

    // Zero flag directed pair (also exercised above)
    applyStimulus(0, 1, 0, 0);
    checkAll("zeroAnd", 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkAll("zeroOr", 1, 1, 0, 0);

    // Random stimulus with decoy input changes mid-cycle; outputs must hold
    for (int n = 0; n < 200; n++) begin
      o = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 1));
      b = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 1));
      applyStimulus(o, a, b, c);
      checkAll("rand", o, a, b, c);
      op      = 2'($urandom_range(0, 3));
      in1     = 1'($urandom_range(0, 1));
      in2     = 1'($urandom_range(0, 1));
      carryIn = 1'($urandom_range(0, 1));
      #2;
      checkAll("hold", o, a, b, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
